// File: rtl/opb_register_ppc2simulink_sync.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_ppc2simulink_sync
// Purpose  : OPB slave register carrying one 32-bit control word from the
//            PowerPC into the fabric. Software writes a shadow register; the
//            shadow is committed to user_data_out either immediately on a
//            DATA write (C_AUTO_COMMIT=1) or by writing the CTRL word. Each
//            commit raises user_data_valid for one cycle.
//            Everything runs on OPB_Clk.
// Ports    : OPB_Clk, OPB_Rst        clock, async active-high reset
//            OPB_ABus/BE/DBus/RNW    OPB request (big-endian bit numbering)
//            OPB_select, OPB_seqAddr transfer request / ignored
//            Sl_DBus, Sl_xferAck     read data (zero outside ack), ack
//            Sl_errAck/retry/toutSup tied low
//            user_data_out/valid     committed word and commit strobe
// Register map (word index from C_BASEADDR):
//            0 DATA  r/w shadow register, byte-enable merged
//            1 CTRL  wr: bit31 (LSB) with BE[3] commits shadow
//                    rd: bit0 (MSB) = pending, bits16:31 = commit count
//            others  acknowledged, read zero, writes ignored
// Revision : 1.0 - initial release
// ============================================================================
module opb_register_ppc2simulink_sync #(
  parameter logic [31:0] C_BASEADDR    = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR    = 32'h00000000,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter logic [31:0] C_INIT_VALUE  = 32'h00000000,
  parameter bit          C_AUTO_COMMIT = 1'b1
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic                        Sl_xferAck,
  output logic [31:0]                 user_data_out,
  output logic                        user_data_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_DESEL = 2'd2
  } state_t;

  localparam logic [C_OPB_AWIDTH-1:0] c_base_addr = C_BASEADDR[C_OPB_AWIDTH-1:0];
  localparam logic [C_OPB_AWIDTH-1:0] c_high_addr = C_HIGHADDR[C_OPB_AWIDTH-1:0];

  state_t             state_q,  state_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [31:0]        user_q,   user_d;
  logic [15:0]        count_q,  count_d;
  logic               valid_q,  valid_d;
  logic [31:0]        rdata_q,  rdata_d;

  logic [31:0]             w_wdata;
  logic [3:0]              w_be;
  logic [31:0]             w_merged;
  logic [C_OPB_AWIDTH-1:0] w_offset;
  logic [C_OPB_AWIDTH-3:0] w_word;
  logic                    w_hit;
  logic                    w_is_data;
  logic                    w_is_ctrl;
  logic                    w_pending;
  logic                    w_commit;
  logic                    w_unused;

  // OPB bit 0 is the MSB, so a plain assignment into a [31:0] vector keeps
  // numeric significance: DBus[0] -> w_wdata[31], BE[0] -> w_be[3].
  assign w_wdata = OPB_DBus;
  assign w_be    = OPB_BE;

  // Address decode
  assign w_offset  = OPB_ABus - c_base_addr;
  assign w_word    = w_offset[C_OPB_AWIDTH-1:2];
  assign w_hit     = OPB_select && (OPB_ABus >= c_base_addr) && (OPB_ABus <= c_high_addr);
  assign w_is_data = (w_word == '0);
  assign w_is_ctrl = (w_word == (C_OPB_AWIDTH-2)'(1));
  assign w_pending = (shadow_q != user_q);

  assign w_unused  = OPB_seqAddr ^ (^w_offset[1:0]);

  // Byte-enable merge of write data into the shadow
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
    assign w_merged[8*gi +: 8] = w_be[gi] ? w_wdata[8*gi +: 8] : shadow_q[8*gi +: 8];
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    user_d   = user_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    rdata_d  = '0;
    w_commit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_hit) begin
          state_d = S_ACK;
          if (OPB_RNW) begin
            if (w_is_data) begin
              rdata_d = shadow_q;
            end else if (w_is_ctrl) begin
              rdata_d = {w_pending, 15'd0, count_q};
            end
          end else begin
            if (w_is_data) begin
              shadow_d = w_merged;
              w_commit = C_AUTO_COMMIT;
            end else if (w_is_ctrl) begin
              w_commit = w_wdata[0] & w_be[0];
            end
          end
        end
      end
      S_ACK: begin
        state_d = S_DESEL;
      end
      S_DESEL: begin
        // One ack per select assertion: wait for the master to let go.
        if (!OPB_select) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // shadow_d already holds the merged value on a DATA write, so an
    // auto-commit publishes the freshly written word at the same edge.
    if (w_commit) begin
      user_d  = shadow_d;
      count_d = count_q + 16'd1;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q  <= S_IDLE;
      shadow_q <= C_INIT_VALUE;
      user_q   <= C_INIT_VALUE;
      count_q  <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      user_q   <= user_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Read data is gated by the ack so the bus stays zero for the wired-OR.
  assign Sl_xferAck      = (state_q == S_ACK);
  assign Sl_DBus         = Sl_xferAck ? rdata_q : '0;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = user_q;
  assign user_data_valid = valid_q;

  // Exposed under a stable name for hierarchical access.
  logic [15:0] commit_count_q;
  assign commit_count_q = count_q;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_ppc2simulink_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_register_ppc2simulink_sync
// Purpose  : Self-checking bench. Two instances share the OPB request lines:
//            A at 0x1000-0x100F (auto-commit, init 0x12345678) and
//            B at 0x2000-0x200F (manual commit, init 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_opb_register_ppc2simulink_sync;

  localparam logic [31:0] A_DATA = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = 32'h0000_1004;
  localparam logic [31:0] B_DATA = 32'h0000_2000;
  localparam logic [31:0] B_CTRL = 32'h0000_2004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  be   = '0;
  logic [0:31] dbus = '0;
  logic        rnw  = 1'b0;
  logic        sel  = 1'b0;
  logic        seqaddr = 1'b0;

  logic [0:31] sl_dbus_a, sl_dbus_b;
  logic        err_a, retry_a, tout_a, ack_a, valid_a;
  logic        err_b, retry_b, tout_b, ack_b, valid_b;
  logic [31:0] udo_a, udo_b;

  logic        ack_any, valid_any;
  logic [31:0] dbus_any;
  assign ack_any   = ack_a | ack_b;
  assign valid_any = valid_a | valid_b;
  assign dbus_any  = sl_dbus_a | sl_dbus_b;

  always #5 clk = ~clk;

  opb_register_ppc2simulink_sync #(
    .C_BASEADDR(32'h0000_1000), .C_HIGHADDR(32'h0000_100F),
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_INIT_VALUE(32'h1234_5678), .C_AUTO_COMMIT(1'b1)
  ) dut_a (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqaddr),
    .Sl_DBus(sl_dbus_a), .Sl_errAck(err_a), .Sl_retry(retry_a),
    .Sl_toutSup(tout_a), .Sl_xferAck(ack_a),
    .user_data_out(udo_a), .user_data_valid(valid_a)
  );

  opb_register_ppc2simulink_sync #(
    .C_BASEADDR(32'h0000_2000), .C_HIGHADDR(32'h0000_200F),
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_INIT_VALUE(32'h0000_0000), .C_AUTO_COMMIT(1'b0)
  ) dut_b (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqaddr),
    .Sl_DBus(sl_dbus_b), .Sl_errAck(err_b), .Sl_retry(retry_b),
    .Sl_toutSup(tout_b), .Sl_xferAck(ack_b),
    .user_data_out(udo_b), .user_data_valid(valid_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observations of the last transfer
  logic [31:0] t_rdata;
  int          t_nack, t_nvalid, t_nvalid_ack, t_nz, t_first_ack;

  // Drive one transfer with select held for 'hold' sampled edges, then keep
  // watching long enough for the slave to return to idle.
  task automatic xfer(input logic [31:0] addr, input logic [3:0] ben,
                      input logic [31:0] wdata, input logic rd, input int hold);
    t_rdata = '0; t_nack = 0; t_nvalid = 0; t_nvalid_ack = 0; t_nz = 0; t_first_ack = -1;
    @(negedge clk);
    abus = addr; be = ben; dbus = wdata; rnw = rd; sel = 1'b1;
    for (int i = 0; i < hold + 3; i++) begin
      @(posedge clk); #1;
      if (ack_any) begin
        t_nack++;
        t_rdata = dbus_any;
        if (t_first_ack < 0) t_first_ack = i;
      end else if (dbus_any != 32'h0) begin
        t_nz++;
      end
      if (valid_any) begin
        t_nvalid++;
        if (ack_any) t_nvalid_ack++;
      end
      if (i == hold - 1) begin
        @(negedge clk);
        sel = 1'b0; dbus = '0;
      end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rnw;
    logic [31:0] exp_rdata;
    int          exp_nack;
    int          exp_nvalid;
    logic [31:0] exp_udo_a;
    logic [31:0] exp_udo_b;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{A_CTRL,       4'b1111, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 32'h1234_5678, 32'h0};
    vecs[1]  = '{A_DATA,       4'b1111, 32'h0,         1'b1, 32'h1234_5678, 1, 0, 32'h1234_5678, 32'h0};
    vecs[2]  = '{A_DATA,       4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1, 1, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{A_CTRL,       4'b1111, 32'h0,         1'b1, 32'h0000_0001, 1, 0, 32'hDEAD_BEEF, 32'h0};
    vecs[4]  = '{A_DATA,       4'b1111, 32'h0,         1'b1, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{A_DATA,       4'b1111, 32'h0000_0000, 1'b0, 32'h0000_0000, 1, 1, 32'h0000_0000, 32'h0};
    vecs[6]  = '{A_DATA,       4'b0101, 32'hAABB_CCDD, 1'b0, 32'h0000_0000, 1, 1, 32'h00BB_00DD, 32'h0};
    vecs[7]  = '{A_DATA,       4'b1111, 32'h0,         1'b1, 32'h00BB_00DD, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[8]  = '{A_CTRL,       4'b1111, 32'h0,         1'b1, 32'h0000_0003, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[9]  = '{32'h0000_1008,4'b1111, 32'h0,         1'b1, 32'h0000_0000, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[10] = '{32'h0000_100C,4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[11] = '{A_DATA,       4'b1111, 32'h0,         1'b1, 32'h00BB_00DD, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[12] = '{A_CTRL,       4'b1111, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 1, 32'h00BB_00DD, 32'h0};
    vecs[13] = '{A_CTRL,       4'b1110, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[14] = '{A_CTRL,       4'b1111, 32'hFFFF_FFFE, 1'b0, 32'h0000_0000, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[15] = '{A_CTRL,       4'b1111, 32'h0,         1'b1, 32'h0000_0004, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[16] = '{B_DATA,       4'b1111, 32'h0000_CAFE, 1'b0, 32'h0000_0000, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[17] = '{B_CTRL,       4'b1111, 32'h0,         1'b1, 32'h8000_0000, 1, 0, 32'h00BB_00DD, 32'h0};
    vecs[18] = '{B_CTRL,       4'b1111, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 1, 32'h00BB_00DD, 32'h0000_CAFE};
    vecs[19] = '{B_CTRL,       4'b1111, 32'h0,         1'b1, 32'h0000_0001, 1, 0, 32'h00BB_00DD, 32'h0000_CAFE};
    vecs[20] = '{32'h0000_1013,4'b1111, 32'h0,         1'b1, 32'h0000_0000, 0, 0, 32'h00BB_00DD, 32'h0000_CAFE};
    vecs[21] = '{32'h0000_1013,4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 0, 0, 32'h00BB_00DD, 32'h0000_CAFE};
    vecs[22] = '{32'h0000_0FFC,4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 0, 0, 32'h00BB_00DD, 32'h0000_CAFE};
    vecs[23] = '{B_DATA,       4'b1100, 32'h1234_0000, 1'b0, 32'h0000_0000, 1, 0, 32'h00BB_00DD, 32'h0000_CAFE};
    vecs[24] = '{B_CTRL,       4'b1111, 32'h0,         1'b1, 32'h8000_0001, 1, 0, 32'h00BB_00DD, 32'h0000_CAFE};
    vecs[25] = '{B_DATA,       4'b1111, 32'h0,         1'b1, 32'h1234_CAFE, 1, 0, 32'h00BB_00DD, 32'h0000_CAFE};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst udo_a",   udo_a,   32'h1234_5678);
    check("rst udo_b",   udo_b,   32'h0);
    check("rst ack_a",   {31'd0, ack_a},   32'h0);
    check("rst valid_a", {31'd0, valid_a}, 32'h0);
    check("rst dbus_a",  sl_dbus_a, 32'h0);
    check("rst tieoffs", {28'd0, err_a, retry_a, tout_a, err_b | retry_b | tout_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven transfers ----------------
    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].rnw, 1);
      check($sformatf("vec%0d rdata", i),     t_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d nack", i),      t_nack, vecs[i].exp_nack);
      check($sformatf("vec%0d nvalid", i),    t_nvalid, vecs[i].exp_nvalid);
      check($sformatf("vec%0d valid@ack", i), t_nvalid_ack, vecs[i].exp_nvalid);
      check($sformatf("vec%0d dbus idle", i), t_nz, 0);
      if (vecs[i].exp_nack == 1)
        check($sformatf("vec%0d ack latency", i), t_first_ack, 0);
      check($sformatf("vec%0d udo_a", i),     udo_a, vecs[i].exp_udo_a);
      check($sformatf("vec%0d udo_b", i),     udo_b, vecs[i].exp_udo_b);
    end

    // ---------------- select held 5 cycles on a read ----------------
    xfer(A_DATA, 4'b1111, 32'h0, 1'b1, 5);
    check("hold5 nack",  t_nack, 1);
    check("hold5 rdata", t_rdata, 32'h00BB_00DD);
    check("hold5 dbus idle", t_nz, 0);
    check("hold5 latency", t_first_ack, 0);

    // ---------------- reset in the ack cycle ----------------
    @(negedge clk);
    abus = A_DATA; be = 4'b1111; dbus = 32'h1111_1111; rnw = 1'b0; sel = 1'b1;
    @(posedge clk); #1;
    check("midrst ack before",   {31'd0, ack_a},   32'h1);
    check("midrst valid before", {31'd0, valid_a}, 32'h1);
    check("midrst udo before",   udo_a, 32'h1111_1111);
    #2 rst = 1'b1;
    #1;
    check("midrst ack",   {31'd0, ack_a},   32'h0);
    check("midrst valid", {31'd0, valid_a}, 32'h0);
    check("midrst udo_a", udo_a, 32'h1234_5678);
    check("midrst udo_b", udo_b, 32'h0);
    check("midrst dbus",  dbus_any, 32'h0);
    // First edge after release must accept a transfer
    @(negedge clk);
    rst = 1'b0; abus = A_DATA; dbus = '0; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #1;
    check("post-rst ack",   {31'd0, ack_a}, 32'h1);
    check("post-rst rdata", dbus_any, 32'h1234_5678);
    @(negedge clk);
    sel = 1'b0;
    repeat (3) @(posedge clk);
    xfer(A_CTRL, 4'b1111, 32'h0, 1'b1, 1);
    check("post-rst ctrl", t_rdata, 32'h0);
    xfer(B_CTRL, 4'b1111, 32'h0, 1'b1, 1);
    check("post-rst ctrl b", t_rdata, 32'h0);

    // ---------------- commit counter wrap ----------------
    // Preload the counter near its wrap point instead of spending 65536
    // transfers; the following commits still go through the real logic.
    @(negedge clk);
    force dut_a.count_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut_a.count_q;
    xfer(A_CTRL, 4'b1111, 32'h0, 1'b1, 1);
    check("wrap pre", t_rdata, 32'h0000_FFFE);
    xfer(A_CTRL, 4'b1111, 32'h0000_0001, 1'b0, 1);
    check("wrap commit1 valid", t_nvalid_ack, 1);
    xfer(A_CTRL, 4'b1111, 32'h0, 1'b1, 1);
    check("wrap ffff", t_rdata, 32'h0000_FFFF);
    xfer(A_CTRL, 4'b1111, 32'h0000_0001, 1'b0, 1);
    check("wrap commit2 valid", t_nvalid_ack, 1);
    xfer(A_CTRL, 4'b1111, 32'h0, 1'b1, 1);
    check("wrap zero", t_rdata, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
